credit_sender: RTL and testbench
================================

Name: credit_sender

Overview:
- Transmit end of the credit-based link whose receive end is the team's credit FIFO.
- Accepts words from an upstream valid/ready source and forwards them on a registered, ready-less link.
- A word is forwarded only while the sender holds a credit. Each word consumes one credit; the receiver returns one credit per word it drains.
- Sits directly upstream of the credit FIFO; MAX_CREDITS must equal that FIFO's DEPTH.

Parameters:
DATA_WIDTH, 32, width of each data word
MAX_CREDITS, 8, initial and maximum credit count (equals receiver FIFO depth); must be >= 1
CNT_W, $clog2(MAX_CREDITS+1), localparam, width of credit counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word available
in_ready  output  1  sender can accept upstream word this cycle
in_data  input  DATA_WIDTH  upstream word
tx_valid  output  1  link word valid (single-cycle qualifier per word)
tx_data  output  DATA_WIDTH  link word
credit_return  input  1  one credit returned this cycle (pulse, one per drained word)
credits_avail  output  CNT_W  current credits held
idle  output  1  all credits home and no word on link
credit_error  output  1  sticky: credit returned while counter already at MAX_CREDITS

Behaviour:
- Reset (async assert, sync release):
  - credits_avail = MAX_CREDITS, tx_valid = 0, tx_data = 0, credit_error = 0.
  - in_ready and idle follow combinationally from these values: in_ready = 1, idle = 1.
- in_ready = (credits_avail != 0). Purely from registered state; no combinational path from in_valid or credit_return.
- Accept: the cycle with in_valid && in_ready is one accept.
  - Next edge: tx_valid = 1, tx_data = in_data, credits_avail decrements by 1.
  - Latency in_data -> tx_data is exactly 1 cycle.
- No accept in a cycle: next edge tx_valid = 0. tx_data holds its last value and is don't-care while tx_valid = 0.
- Back-to-back accepts give one tx_valid pulse per word on consecutive cycles (full throughput while credits remain).
- credit_return alone: credits_avail increments by 1.
- Accept and credit_return in the same cycle: credits_avail unchanged.
- Zero credits: in_ready = 0. A credit_return in that cycle does not enable acceptance until the next cycle (credits_avail = 1).
- Overflow:
  - Condition: credit_return with credits_avail == MAX_CREDITS and no accept in that cycle.
  - Result: credits_avail saturates at MAX_CREDITS and credit_error sets next edge, sticky until reset.
  - A return at MAX coincident with an accept is legal: net change 0, no error.
- Arithmetic: the counter never underflows (accept requires a nonzero count) and never exceeds MAX_CREDITS.
- idle = (credits_avail == MAX_CREDITS) && !tx_valid. Combinational from registers.
- Reset mid-operation: any tx_valid pulse is dropped and credits restore to MAX_CREDITS. The receiver must be reset together with the sender.

Test Plan:
- Reset, then check outputs -> credits_avail = 8, in_ready = 1, tx_valid = 0, idle = 1, credit_error = 0.
- Burst: present words 0xA0..0xA7 with in_valid held, no returns:
  - tx_valid high for 8 consecutive cycles, each starting 1 cycle after its accept, with data 0xA0..0xA7 in order.
  - credits_avail reaches 0, in_ready drops; a 9th word 0xA8 is held and not sent.
- With 0 credits, pulse credit_return once -> credits_avail = 1 next cycle, 0xA8 accepted that cycle, tx_data = 0xA8 one cycle later, credits_avail back to 0.
- Steady state at credits_avail = 3: accept and credit_return in the same cycle for 10 cycles -> credits_avail stays 3, 10 tx_valid pulses in order.
- At credits_avail = 8 with idle: pulse credit_return -> credit_error = 1 and stays 1, credits_avail stays 8. Repeat with a coincident accept -> no error, credits_avail = 8.
- Assert rst_n low asynchronously mid-burst with credits_avail = 5 -> tx_valid = 0 and credits_avail = 8 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/credit_sender.sv
// credit_sender: transmit end of a credit-based link.
// Words from a valid/ready source are forwarded one cycle later on a
// registered, ready-less link. Each forwarded word spends one credit, and
// the receiver returns one credit for each word it drains.
module credit_sender #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_CREDITS = 8,
    localparam int CNT_W      = $clog2(MAX_CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  credit_return,
    output logic [CNT_W-1:0]      credits_avail,
    output logic                  idle,
    output logic                  credit_error
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CREDITS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [CNT_W-1:0] credits_q;
    logic [CNT_W-1:0] credits_d;
    logic             accept;
    logic             overflow;

    // Acceptance depends only on the registered count, so a credit returned
    // at zero credits enables acceptance only from the following cycle.
    assign in_ready      = (credits_q != '0);
    assign accept        = in_valid && in_ready;
    assign overflow      = credit_return && !accept && (credits_q == MAX_CNT);
    assign credits_avail = credits_q;
    assign idle          = (credits_q == MAX_CNT) && !tx_valid;

    // Next credit count: spend on accept, refund on return, saturate at max.
    always_comb begin
        // NOTE: default assigned first so every path drives credits_d; no latch is inferred.
        credits_d = credits_q;
        unique case ({accept, credit_return})
            2'b10:   credits_d = credits_q - ONE_CNT;
            2'b01:   credits_d = (credits_q == MAX_CNT) ? MAX_CNT : credits_q + ONE_CNT;
            default: credits_d = credits_q;
        endcase
    end

    // Credit counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q    <= MAX_CNT;
            credit_error <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            credits_q <= credits_d;
            if (overflow) begin
                credit_error <= 1'b1;
            end
        end
    end

    // Link register: one valid pulse per accepted word; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_valid <= accept;
            if (accept) begin
                tx_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_credit_sender.sv
// Directed testbench for credit_sender with hand-computed expectations.
module tb_credit_sender;

    localparam int DW    = 32;
    localparam int MAXC  = 8;
    localparam int CW    = $clog2(MAXC + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          credit_return;
    logic [CW-1:0] credits_avail;
    logic          idle;
    logic          credit_error;

    int n_tests;
    int n_fail;

    credit_sender #(.DATA_WIDTH(DW), .MAX_CREDITS(MAXC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .credit_return (credit_return),
        .credits_avail (credits_avail),
        .idle          (idle),
        .credit_error  (credit_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        credit_return = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_async_credits", 32'(credits_avail), 32'd8);
        do_reset();

        check("rst_credits",  32'(credits_avail), 32'd8);
        check("rst_in_ready", 32'(in_ready),      32'd1);
        check("rst_tx_valid", 32'(tx_valid),      32'd0);
        check("rst_tx_data",  tx_data,            32'd0);
        check("rst_idle",     32'(idle),          32'd1);
        check("rst_error",    32'(credit_error),  32'd0);

        // Burst of 8 words spends every credit.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'hA0 + 32'(i);
            step();
            check("burst_valid",   32'(tx_valid),      32'd1);
            check("burst_data",    tx_data,            32'hA0 + 32'(i));
            check("burst_credits", 32'(credits_avail), 32'(7 - i));
        end
        check("zero_in_ready", 32'(in_ready), 32'd0);
        check("zero_idle",     32'(idle),     32'd0);

        // Ninth word is held while no credits are available.
        in_data = 32'hA8;
        for (int i = 0; i < 2; i++) begin
            step();
            check("held_valid",   32'(tx_valid),      32'd0);
            check("held_credits", 32'(credits_avail), 32'd0);
        end

        // One return at zero credits; acceptance only on the following cycle.
        credit_return = 1'b1;
        check("ret_zero_ready_same_cycle", 32'(in_ready), 32'd0);
        step();
        credit_return = 1'b0;
        check("ret_zero_valid",   32'(tx_valid),      32'd0);
        check("ret_zero_credits", 32'(credits_avail), 32'd1);
        check("ret_zero_ready",   32'(in_ready),      32'd1);
        step();
        in_valid = 1'b0;
        check("a8_valid",   32'(tx_valid),      32'd1);
        check("a8_data",    tx_data,            32'hA8);
        check("a8_credits", 32'(credits_avail), 32'd0);

        // Return three credits.
        credit_return = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("refill_credits", 32'(credits_avail), 32'(i));
        end

        // Steady state: accept and return in the same cycle, count holds at 3.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'hB0 + 32'(i);
            step();
            check("steady_valid",   32'(tx_valid),      32'd1);
            check("steady_data",    tx_data,            32'hB0 + 32'(i));
            check("steady_credits", 32'(credits_avail), 32'd3);
        end
        in_valid = 1'b0;
        for (int i = 4; i <= 8; i++) begin
            step();
            check("refill2_credits", 32'(credits_avail), 32'(i));
        end
        credit_return = 1'b0;
        check("full_valid", 32'(tx_valid), 32'd1 - 32'd1);
        check("full_idle",  32'(idle),     32'd1);
        check("full_error", 32'(credit_error), 32'd0);

        // Overflow: return at max with no accept sets the sticky error.
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("ovf_error",   32'(credit_error),  32'd1);
        check("ovf_credits", 32'(credits_avail), 32'd8);
        step();
        step();
        check("ovf_sticky",  32'(credit_error),  32'd1);
        check("ovf_credits2", 32'(credits_avail), 32'd8);

        // Return at max coincident with an accept is legal.
        do_reset();
        check("rst2_error", 32'(credit_error), 32'd0);
        in_valid      = 1'b1;
        in_data       = 32'hC5;
        credit_return = 1'b1;
        step();
        in_valid      = 1'b0;
        credit_return = 1'b0;
        check("coinc_error",   32'(credit_error),  32'd0);
        check("coinc_credits", 32'(credits_avail), 32'd8);
        check("coinc_valid",   32'(tx_valid),      32'd1);
        check("coinc_data",    tx_data,            32'hC5);
        check("coinc_idle",    32'(idle),          32'd0);
        step();
        check("coinc_idle_after", 32'(idle),        32'd1);
        check("coinc_error_after", 32'(credit_error), 32'd0);

        // Asynchronous reset mid-burst at 5 credits.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hD0 + 32'(i);
            step();
        end
        check("pre_rst_credits", 32'(credits_avail), 32'd5);
        check("pre_rst_valid",   32'(tx_valid),      32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",   32'(tx_valid),      32'd0);
        check("async_rst_credits", 32'(credits_avail), 32'd8);
        check("async_rst_ready",   32'(in_ready),      32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 32'(idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
